// File: rtl/bram_rdata_fifo.sv
// bram_rdata_fifo
// Read-return buffer between the BRAM controller and the CPU read port.
// Words returning from the controller (no backpressure) are stored in order
// and presented first-word-fall-through on a valid/ready port. Reads still in
// flight in the controller are tracked so the arbiter only gets issue credit
// when a returning word is guaranteed a free slot.
//
// Handshake: the head entry transfers on any rising edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready.
// in_valid is a plain strobe and is sampled every cycle; a word that
// arrives while the buffer is full and nothing pops is dropped and
// flagged on the sticky overflow output.

module bram_rdata_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          rd_issue,
    output logic          credit_ok,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic [AW:0]   outstanding,
    output logic          overflow
);

    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [AW:0]   OUT_MAX = '1;

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   outstanding_q, outstanding_d;
    logic          overflow_q, overflow_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [AW:0]   count_w;
    logic [AW+1:0] credit_sum;

    // Status, handshake decode and next-state computation.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);
        count_w    = wr_ptr_q - rd_ptr_q;
        pop        = ~empty & out_ready;
        // A pop in the same cycle frees the slot, so a full buffer still accepts.
        push       = in_valid & (~full | pop);
        drop       = in_valid & full & ~pop;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q | drop;

        // Issue and return in the same cycle cancel. Unsolicited returns
        // (e.g. words already in flight across a reset) must not underflow.
        outstanding_d = outstanding_q;
        if (rd_issue && !in_valid && outstanding_q != OUT_MAX) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (in_valid && !rd_issue && outstanding_q != '0) begin
            outstanding_d = outstanding_q - 1'b1;
        end

        // Extra bit so count + outstanding cannot wrap before the compare.
        credit_sum = {1'b0, count_w} + {1'b0, outstanding_q};
    end

    // Pointer, outstanding and sticky overflow state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Output drive: head word is forced to zero whenever the buffer is empty.
    always_comb begin
        out_valid   = ~empty;
        out_data    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        count       = count_w;
        outstanding = outstanding_q;
        overflow    = overflow_q;
        credit_ok   = (credit_sum < DEPTH_W);
    end

endmodule

// File: tb/tb_bram_rdata_fifo.sv
// tb_bram_rdata_fifo
// Directed and random stimulus for bram_rdata_fifo with a queue-based
// scoreboard holding the words expected at the CPU port in order.

module tb_bram_rdata_fifo;

  localparam int DW      = 32;
  localparam int DEPTH   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int OUT_MAX = 2 * DEPTH - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          rd_issue;
  logic          credit_ok;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   count;
  logic [AW:0]   outstanding;
  logic          overflow;

  logic [DW-1:0] exp_q[$];
  int            m_out;
  logic          m_ovf;
  logic [DW-1:0] last_pop;
  int            total;
  int            bad;

  bram_rdata_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .rd_issue    (rd_issue),
    .credit_ok   (credit_ok),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .outstanding (outstanding),
    .overflow    (overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_out = 0;
    m_ovf = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_count"}, count, '0);
    chk({tag, "_outstanding"}, outstanding, '0);
    chk({tag, "_credit_ok"}, credit_ok, 1'b1);
    chk({tag, "_overflow"}, overflow, 1'b0);
  endtask

  // driver: called at posedge+1, applies one cycle of inputs, updates the model
  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ri, input logic ordy);
    int   sz;
    logic pop_m;
    in_valid  = iv;
    in_data   = d;
    rd_issue  = ri;
    out_ready = ordy;
    #1;
    sz = exp_q.size();
    chk("out_valid", out_valid, sz > 0);
    if (sz > 0) chk("out_data", out_data, exp_q[0]);
    else        chk("out_data_empty", out_data, '0);
    chk("credit_ok", credit_ok, (sz + m_out) < DEPTH);
    pop_m = (sz > 0) && ordy;
    if (pop_m) last_pop = exp_q.pop_front();
    if (iv) begin
      if (sz < DEPTH || pop_m) exp_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (ri && !iv && m_out != OUT_MAX) m_out++;
    else if (iv && !ri && m_out != 0) m_out--;
    @(posedge clk);
    #1;
    chk("count", count, exp_q.size());
    chk("outstanding", outstanding, m_out);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    rd_issue  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    model_clear();
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_pop = '0;
    model_clear();

    // reset values
    do_reset();

    // three words buffered, then drained in order
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    chk("t1_count3", count, 3);
    chk("t1_head", out_data, 32'h11);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t1_pop1", last_pop, 32'h11);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t1_pop2", last_pop, 32'h22);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t1_pop3", last_pop, 32'h33);
    chk("t1_empty_valid", out_valid, 1'b0);
    chk("t1_empty_data", out_data, '0);

    // credit: 16 issues with no returns
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (i == DEPTH - 2) chk("t2_credit_before_last", credit_ok, 1'b1);
    end
    chk("t2_credit_low", credit_ok, 1'b0);
    chk("t2_outstanding16", outstanding, DEPTH);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
    chk("t2_outstanding0", outstanding, 0);
    chk("t2_count16", count, DEPTH);
    chk("t2_credit_full", credit_ok, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t2_credit_after_pop", credit_ok, 1'b1);
    chk("t2_pop_first", last_pop, 32'h100);
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    chk("t3_refull", count, DEPTH);

    // full with simultaneous push and pop
    drive(1'b1, 32'hAA, 1'b0, 1'b1);
    chk("t3_count_held", count, DEPTH);
    chk("t3_no_overflow", overflow, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("t3_aa_last", last_pop, 32'hAA);
    chk("t3_drained", out_valid, 1'b0);

    // full with no pop: word dropped, overflow sticky
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h300 + i, 1'b0, 1'b0);
    drive(1'b1, 32'hBB, 1'b0, 1'b0);
    chk("t4_count16", count, DEPTH);
    chk("t4_overflow", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("t4_last_not_bb", last_pop, 32'h30F);
    chk("t4_overflow_sticky", overflow, 1'b1);

    // random push/pop/issue with pointer wrap
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, 1'b0, 1'b1);
    chk("t5_drained", exp_q.size() == 0 && out_valid == 1'b0, 1'b1);

    // unsolicited return leaves outstanding at zero, then reset mid-stream
    do_reset();
    drive(1'b1, 32'h5A, 1'b0, 1'b0);
    chk("t6_unsolicited", outstanding, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h60 + i, 1'b1, 1'b0);
    chk("t6_count5", count, 5);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    chk("t6_after_reset_outstanding", outstanding, 0);
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t6_after_reset_word", last_pop, 32'h77);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
